biriscv_iter_div: RTL and testbench

BIRISCV_ITER_DIV -- requirements
Module: biriscv_iter_div

---
 rtl/biriscv_iter_div.sv | 74 +++++++
 tb/tb_biriscv_iter_div.sv | 135 +++++++++++++
 2 files changed

// File: rtl/biriscv_iter_div.sv
// biriscv_iter_div: iterative restoring radix-2 divider for DIV/DIVU/REM/REMU
module biriscv_iter_div #(
  parameter int DIV0_FAST_PATH = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] operand_ra_i,
  input  logic [31:0] operand_rb_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        div_complete_o,
  output logic [31:0] div_result_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0]  cnt;
  logic        fin, rem_op, neg_q, neg_r, accept, sgn, b_zero, fast;
  logic [31:0] quo, rem, dvs, abs_a, abs_b;
  logic [32:0] shl, diff;
  assign sgn    = ~div_op_i[0];
  assign abs_a  = (sgn && operand_ra_i[31]) ? -operand_ra_i : operand_ra_i;
  assign abs_b  = (sgn && operand_rb_i[31]) ? -operand_rb_i : operand_rb_i;
  assign b_zero = operand_rb_i == 32'd0;
  assign fast   = (DIV0_FAST_PATH != 0) && b_zero;
  assign accept = state == IDLE && opcode_valid_i && !flush_i;
  assign shl    = {rem, quo[31]};
  assign diff   = shl - {1'b0, dvs};
  assign busy_o         = state == RUN;
  assign div_complete_o = state == DONE;
  // State register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  // Next state: RUN ends once the final step has been taken (fin), or on flush
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = flush_i ? IDLE : fin ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  // Datapath: capture magnitudes, one quotient bit per cycle, then sign-fix the result
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt          <= 5'd0;
      fin          <= 1'b0;
      rem_op       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      quo          <= 32'd0;
      rem          <= 32'd0;
      dvs          <= 32'd0;
      div_result_o <= 32'd0;
    end else if (accept) begin
      cnt    <= 5'd0;
      fin    <= fast;
      rem_op <= div_op_i[1];
      neg_q  <= sgn && !div_op_i[1] && (operand_ra_i[31] ^ operand_rb_i[31]) && !b_zero;
      neg_r  <= sgn && div_op_i[1] && operand_ra_i[31];
      dvs    <= abs_b;
      quo    <= fast ? 32'hFFFF_FFFF : abs_a;
      rem    <= fast ? abs_a : 32'd0;
    end else if (state == RUN && !fin) begin
      quo <= {quo[30:0], ~diff[32]};
      rem <= diff[32] ? shl[31:0] : diff[31:0];
      cnt <= cnt + 5'd1;
      fin <= cnt == 5'd31;
    end else if (state == RUN && !flush_i) begin
      div_result_o <= rem_op ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    end
endmodule

// File: tb/tb_biriscv_iter_div.sv
// tb_biriscv_iter_div: scoreboard bench for the iterative divider
module tb_biriscv_iter_div;
  logic        clk = 0, rst = 1, opcode_valid = 0, flush = 0;
  logic [1:0]  div_op = 0;
  logic [31:0] ra = 0, rb = 0;
  logic        busy, complete;
  logic [31:0] result;
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] last_res = 0;
  typedef struct {logic [31:0] res; int due;} exp_t;
  exp_t sb[$];
  biriscv_iter_div dut (
    .clk_i(clk), .rst_i(rst), .opcode_valid_i(opcode_valid), .div_op_i(div_op),
    .operand_ra_i(ra), .operand_rb_i(rb), .flush_i(flush),
    .busy_o(busy), .div_complete_o(complete), .div_result_o(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic r;
    r = op[1];
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
      return r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return r ? a % b : a / b;
  endfunction
  always @(negedge clk)
    if (!rst && complete) begin
      if (sb.size() == 0) check("spurious_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", cyc, e.due);
        last_res = e.res;
      end
    end
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    opcode_valid = 1; div_op = op; ra = a; rb = b;
    @(posedge clk); #1;
    opcode_valid = 0;
    if (push) sb.push_back('{model(op, a, b), cyc + ((b == 0) ? 1 : 33)});
    if (b != 0) check("busy_run", busy, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1);
    wait_done();
  endtask
  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_complete", complete, 0);
    check("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run(2'b01, 100, 7);
    run(2'b11, 100, 7);
    run(2'b00, 32'hFFFF_FFF9, 2);
    run(2'b10, 32'hFFFF_FFF9, 2);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b01, 32'h1234, 0);
    run(2'b11, 32'h1234, 0);
    run(2'b00, 32'hFFFF_FFFB, 0);
    run(2'b10, 32'hFFFF_FFFB, 0);
    run(2'b10, 32'd17, 32'hFFFF_FFFB);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run(2'($urandom_range(0, 3)), a, b);
    end
    issue(2'b01, 1000, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      opcode_valid = 1; div_op = 2'b11; ra = 99; rb = 4;
    end
    @(negedge clk) opcode_valid = 0;
    wait_done();
    @(negedge clk);
    opcode_valid = 1; flush = 1; div_op = 2'b01; ra = 9; rb = 3;
    @(posedge clk); #1;
    check("idle_flush_busy", busy, 0);
    opcode_valid = 0; flush = 0;
    repeat (40) @(negedge clk);
    issue(2'b01, 50, 5, 0);
    repeat (10) @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_busy", busy, 0);
    check("flush_result_kept", result, last_res);
    repeat (40) @(negedge clk);
    check("flush_result_hold", result, last_res);
    run(2'b01, 50, 5);
    issue(2'b01, 77, 3, 0);
    repeat (15) @(negedge clk);
    @(posedge clk);
    rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_complete", complete, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst = 0;
    opcode_valid = 1; div_op = 2'b11; ra = 77; rb = 3;
    @(posedge clk); #1;
    opcode_valid = 0;
    sb.push_back('{model(2'b11, 77, 3), cyc + 33});
    check("post_rst_accept", busy, 1);
    wait_done();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
